// File: rtl/seq_pattern_counter.sv
// Programmable serial pattern detector with a Mealy match flag, a BCD match counter
// and registered active-low 7-segment decode of each counter digit.
module seq_pattern_counter #(
    parameter int               PAT_W       = 8,
    parameter int               DIGITS      = 2,
    parameter int               SATURATE    = 1,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 'b101,
    parameter int               DEFAULT_LEN = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         sig_in,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         clr_count,
    output logic                         z,
    output logic [4*DIGITS-1:0]          count_bcd,
    output logic                         overflow,
    output logic [7*DIGITS-1:0]          seg
);

    localparam int LW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] pattern;
    logic [LW-1:0]    len;
    logic             overlap;
    logic [PAT_W-2:0] hist;
    logic [LW-1:0]    fill;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             hit;
    logic             cfg_ok;

    // Current bit sits below the stored history, so bit len-1 is the oldest compared bit.
    assign window = {hist, sig_in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit    = (fill >= len - LW'(1)) && (((window ^ pattern) & mask) == '0);
    assign z      = ena & ~cfg_load & hit;
    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(PAT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= DEFAULT_PAT;
            len     <= LW'(DEFAULT_LEN);
            overlap <= 1'b1;
            hist    <= '0;
            fill    <= '0;
        end else if (cfg_load) begin
            // A rejected load still flushes history so detection restarts cleanly.
            if (cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
            end
            hist <= '0;
            fill <= '0;
        end else if (ena) begin
            if (z && !overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PAT_W-2:0];
                if (fill != LW'(PAT_W - 1)) begin
                    fill <= fill + LW'(1);
                end
            end
        end
    end

    logic [4*DIGITS-1:0] inc_val;
    logic                carry;
    logic                all_nines;

    // Ripple BCD increment; when every digit is 9 the result is all zeros with carry out.
    always_comb begin
        inc_val = count_bcd;
        carry   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (count_bcd[4*d +: 4] == 4'd9) begin
                    inc_val[4*d +: 4] = 4'd0;
                end else begin
                    inc_val[4*d +: 4] = count_bcd[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            count_bcd <= '0;
            overflow  <= 1'b0;
        end else if (z) begin
            if (all_nines) begin
                overflow <= 1'b1;
                if (SATURATE == 0) begin
                    count_bcd <= inc_val;
                end
            end else begin
                count_bcd <= inc_val;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b0000111;
        endcase
    endfunction

    // Display lags the counter by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {DIGITS{7'b1000000}};
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                seg[7*d +: 7] <= seg7(count_bcd[4*d +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Bench for seq_pattern_counter: saturating and wrapping instances share one stimulus stream;
// each driven cycle queues its expected response, checked by a monitor on the falling edge.
module tb_seq_pattern_counter;

    localparam logic [6:0]  S0    = 7'b1000000;
    localparam logic [6:0]  S1    = 7'b1111001;
    localparam logic [6:0]  S2    = 7'b0100100;
    localparam logic [6:0]  S9    = 7'b0011000;

    logic       clk = 1'b0;
    logic       rst, ena, sig_in, cfg_load, cfg_overlap, clr_count;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;

    logic        z_s, ov_s, z_w, ov_w;
    logic [7:0]  cnt_s, cnt_w;
    logic [13:0] seg_s, seg_w;

    always #5 clk = ~clk;

    seq_pattern_counter #(.PAT_W(8), .DIGITS(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .sig_in(sig_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr_count(clr_count), .z(z_s), .count_bcd(cnt_s), .overflow(ov_s), .seg(seg_s)
    );

    seq_pattern_counter #(.PAT_W(8), .DIGITS(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .ena(ena), .sig_in(sig_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr_count(clr_count), .z(z_w), .count_bcd(cnt_w), .overflow(ov_w), .seg(seg_w)
    );

    // State expectations describe what is visible during the cycle the record is issued in.
    typedef struct packed {
        logic [15:0] id;
        logic        z;
        logic        chk_st;
        logic [7:0]  cnt_s;
        logic        ov_s;
        logic [7:0]  cnt_w;
        logic        ov_w;
        logic        chk_seg;
        logic [13:0] seg;
    } exp_t;

    exp_t exp_q[$];

    int passed = 0;
    int total  = 0;

    logic        pend_st  = 1'b0;
    logic        pend_seg = 1'b0;
    logic [7:0]  pend_cnt_s, pend_cnt_w;
    logic        pend_ov_s, pend_ov_w;
    logic [13:0] pend_seg_v;
    logic [15:0] step_id = '0;

    task automatic check(input string name, input logic [15:0] id,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("z_sat", e.id, 32'(z_s), 32'(e.z));
            check("z_wrap", e.id, 32'(z_w), 32'(e.z));
            if (e.chk_st) begin
                check("count_sat", e.id, 32'(cnt_s), 32'(e.cnt_s));
                check("ovf_sat", e.id, 32'(ov_s), 32'(e.ov_s));
                check("count_wrap", e.id, 32'(cnt_w), 32'(e.cnt_w));
                check("ovf_wrap", e.id, 32'(ov_w), 32'(e.ov_w));
            end
            if (e.chk_seg) check("seg_sat", e.id, 32'(seg_s), 32'(e.seg));
        end
    end

    task automatic drive(input logic r, e, s, ld, input logic [7:0] pat,
                         input logic [3:0] len, input logic ov, clr, ez);
        exp_t rec;
        rst = r; ena = e; sig_in = s; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; clr_count = clr;
        rec.id      = step_id;
        rec.z       = ez;
        rec.chk_st  = pend_st;
        rec.cnt_s   = pend_cnt_s;
        rec.ov_s    = pend_ov_s;
        rec.cnt_w   = pend_cnt_w;
        rec.ov_w    = pend_ov_w;
        rec.chk_seg = pend_seg;
        rec.seg     = pend_seg_v;
        exp_q.push_back(rec);
        pend_st  = 1'b0;
        pend_seg = 1'b0;
        step_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic bitx(input logic s, input logic ez);
        drive(1'b0, 1'b1, s, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ez);
    endtask

    task automatic hold(input logic s);
        drive(1'b0, 1'b0, s, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        drive(1'b0, 1'b0, 1'b0, 1'b1, pat, len, ov, 1'b0, 1'b0);
    endtask

    task automatic clr();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect_cnt(input logic [7:0] cs, input logic os,
                              input logic [7:0] cw, input logic ow);
        pend_st = 1'b1; pend_cnt_s = cs; pend_ov_s = os; pend_cnt_w = cw; pend_ov_w = ow;
    endtask

    task automatic expect_seg(input logic [13:0] s);
        pend_seg = 1'b1; pend_seg_v = s;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; sig_in = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset state, then default 101 with overlap.
        expect_cnt(8'h00, 1'b0, 8'h00, 1'b0);
        expect_seg({S0, S0});
        bitx(1, 0); bitx(0, 0); bitx(1, 1); bitx(0, 0); bitx(1, 1);
        expect_cnt(8'h02, 1'b0, 8'h02, 1'b0);
        expect_seg({S0, S1});
        hold(0);
        expect_seg({S0, S2});
        hold(0);
        clr();

        // Non-overlapping 101: the matching bit is consumed.
        load(8'b101, 4'd3, 1'b0);
        expect_cnt(8'h00, 1'b0, 8'h00, 1'b0);
        bitx(1, 0); bitx(0, 0); bitx(1, 1); bitx(0, 0); bitx(1, 0);
        expect_cnt(8'h01, 1'b0, 8'h01, 1'b0);
        bitx(0, 0); bitx(1, 1);
        expect_cnt(8'h02, 1'b0, 8'h02, 1'b0);

        // 0110 with enable gaps: history holds and z stays low while disabled.
        load(8'b0110, 4'd4, 1'b1);
        bitx(0, 0); bitx(1, 0); bitx(1, 0);
        hold(1); hold(0);
        bitx(0, 1);
        expect_cnt(8'h03, 1'b0, 8'h03, 1'b0);

        // Single-bit pattern: every enabled 1 is a match; drive counter to its limit.
        clr();
        load(8'b1, 4'd1, 1'b1);
        expect_cnt(8'h00, 1'b0, 8'h00, 1'b0);
        bitx(0, 0);
        for (int i = 0; i < 9; i++) bitx(1, 1);
        expect_cnt(8'h09, 1'b0, 8'h09, 1'b0);
        bitx(1, 1);
        expect_cnt(8'h10, 1'b0, 8'h10, 1'b0);
        for (int i = 0; i < 89; i++) bitx(1, 1);
        expect_cnt(8'h99, 1'b0, 8'h99, 1'b0);
        bitx(1, 1);
        expect_cnt(8'h99, 1'b1, 8'h00, 1'b1);
        bitx(1, 1);
        expect_cnt(8'h99, 1'b1, 8'h01, 1'b1);
        expect_seg({S9, S9});
        hold(0);

        // Clear beats a coincident match.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        expect_cnt(8'h00, 1'b0, 8'h00, 1'b0);
        load(8'b101, 4'd3, 1'b1);
        bitx(1, 0); bitx(0, 0);
        // Invalid length on a would-be matching bit: z forced low, config kept, history flushed.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        bitx(1, 0); bitx(0, 0); bitx(1, 1);
        load(8'hff, 4'd9, 1'b0);
        bitx(1, 0); bitx(1, 0); bitx(1, 0); bitx(0, 0); bitx(1, 1);
        expect_cnt(8'h02, 1'b0, 8'h02, 1'b0);

        // Reset mid-pattern discards partial history and clears the count.
        bitx(1, 0); bitx(0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        bitx(1, 0);
        expect_cnt(8'h00, 1'b0, 8'h00, 1'b0);
        expect_seg({S0, S0});
        hold(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
